ipsxe_floating_point_mac_pipe_v1_0: RTL and testbench
=====================================================

# ipsxe_floating_point_mac_pipe_v1_0

Parametrised, pipelined multiply-add/subtract unit computing `P = addend ± (A × B)`. The addend is either an external operand or an internal accumulator. It has a valid-qualified streaming interface, selectable latency and per-result overflow detection. It is the behavioural successor to the fixed single-APM `a0_lo ± a1·y` stage, for use in mantissa-refinement datapaths (reciprocal, invsqrt) across all precisions.

## Interface
Parameters:
- `A_WIDTH`, 25: multiplicand width (unsigned).
- `B_WIDTH`, 18: multiplier width (unsigned).
- `C_WIDTH`, 47: external addend width (unsigned, zero-extended).
- `P_WIDTH`, 48: result width (two's complement). Elaboration fails unless `P_WIDTH ≥ A_WIDTH+B_WIDTH+1` and `P_WIDTH ≥ C_WIDTH+1`.
- `LATENCY`, 3: input-to-output cycles, legal range 1..4. Elaboration fails outside this range.

Ports (reset is synchronous and active-high; single clock `i_clk`):
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous active-high reset.
- `i_valid`  in  1  operand set valid this cycle.
- `i_a`  in  A_WIDTH  multiplicand.
- `i_b`  in  B_WIDTH  multiplier.
- `i_c`  in  C_WIDTH  external addend.
- `i_sub`  in  1  1: addend − A·B; 0: addend + A·B.
- `i_acc`  in  1  1: addend is the internal accumulator; 0: addend is `i_c`.
- `o_valid`  out  1  result valid.
- `o_p`  out  P_WIDTH  result.
- `o_ovf`  out  1  true result not representable in P_WIDTH signed.

## Operation
- No back-pressure; the pipeline advances every cycle.
- `i_a`, `i_b`, `i_c`, `i_sub`, `i_acc` are sampled only when `i_valid`=1. Otherwise they are don't-care.
- Product `A·B` is exact, A_WIDTH+B_WIDTH bits unsigned, zero-extended to P_WIDTH+1.
- Post-add is performed in P_WIDTH+1 signed bits. `o_p` = low P_WIDTH bits (wrap-around). `o_ovf` = (bit P_WIDTH ≠ bit P_WIDTH−1).
- The post-add is performed in the final stage. When `i_acc`=1, the addend is the accumulator value at the cycle the operation reaches the final stage. This allows back-to-back accumulation with no hazard at any LATENCY.
- Accumulator = the last `o_p` emitted with `o_valid`=1. It updates on every valid result, whether or not that result used `i_acc`. Reset value is 0.
- Accumulator carries the wrapped value after overflow.
- Bubble cycles (`i_valid`=0): `o_valid`=0. `o_p`, `o_ovf` and the accumulator hold their values.
- Reset:
  - All stage valid bits, `o_valid`, `o_p`, `o_ovf` and the accumulator go to 0 on the clock edge where `i_rst`=1.
  - In-flight operations are discarded.
  - Inputs presented while `i_rst`=1 are discarded.

## Timing
- Operation accepted at edge *n* appears with `o_valid`=1 after edge *n+LATENCY−1*, i.e. on the registered output LATENCY cycles after presentation. Throughput is 1 per cycle.
- LATENCY=1: inputs → combinational multiply + add → output register.
- LATENCY=2: input register, then multiply + add into the output register.
- LATENCY=3: input, product, output registers.
- LATENCY=4: input, product, product-pipe, output registers.
- Addend `i_c`, `i_sub`, `i_acc` and valid are delayed alongside the product to stay aligned.
- First valid output after reset release: no earlier than LATENCY cycles after the first accepted input.

## Structure
- Shared package `ipsxe_floating_point_mac_pkg`:
  - `MAC_LATENCY_MIN`=1 and `MAC_LATENCY_MAX`=4.
  - Width-check function `mac_p_width_ok(a,b,c,p)`.
- Sub-module `ipsxe_floating_point_delay_line_v1_0` (parameters WIDTH, DEPTH≥0; sync reset clears contents). Used for the valid/control/addend alignment path.
- Multiply and post-add stay in the top module so synthesis can map them onto one APM.

## Test plan
- Reset:
  - Hold `i_rst`=1 for 3 cycles with `i_valid`=1 → `o_valid`=0, `o_p`=0, `o_ovf`=0 throughout.
  - First input after release appears exactly LATENCY cycles later.
- Basic add/sub (defaults):
  - a=3, b=5, c=100, sub=0 → `o_p`=115.
  - Next cycle sub=1 → `o_p`=85.
  - Both results back-to-back, LATENCY cycles after input.
- Accumulate chain:
  - a=2, b=2, c=0, acc=0 → 4.
  - Then three consecutive acc=1, a=1, b=1 → 5, 6, 7 on consecutive cycles, for each LATENCY 1..4.
- Negative and overflow, with A=4, B=4, C=8, P=10:
  - c=0, a=1, b=1, sub=1 → `o_p`=0x3FF, `o_ovf`=0.
  - c=255, a=15, b=15 → 480, `o_ovf`=0.
  - Then acc=1, a=15, b=15 → `o_p`=705−1024=−319 (0x2C1), `o_ovf`=1.
- Bubbles: valid pattern 1,0,0,1 → `o_valid` mirrors it LATENCY cycles later; `o_p` holds across the gap; an acc=1 op after the gap uses the pre-gap result.
- Reset mid-flight:
  - Two operations in flight, assert `i_rst` for 1 cycle → neither emerges.
  - Next acc=1, a=1, b=1 → `o_p`=1 (accumulator cleared).

Source files
------------

// File: rtl/ipsxe_floating_point_mac_pkg.sv
// Shared constants and elaboration helpers for the pipelined multiply-add unit.
package ipsxe_floating_point_mac_pkg;

  localparam int unsigned MAC_LATENCY_MIN = 1;
  localparam int unsigned MAC_LATENCY_MAX = 4;

  // The result needs one bit above the product and above the addend for the sign.
  function automatic bit mac_p_width_ok(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned p);
    return (p >= a + b + 1) && (p >= c + 1);
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_delay_line_v1_0.sv
// Fixed-depth shift register with synchronous clear; DEPTH=0 is a plain wire.
module ipsxe_floating_point_delay_line_v1_0 #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_d
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, i_clk, i_rst};
    assign o_d = i_d;
  end else begin : g_shift
    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          sr_q[i] <= '0;
        end
      end else begin
        sr_q[0] <= i_d;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end

    assign o_d = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/ipsxe_floating_point_mac_pipe_v1_0.sv
// Pipelined P = addend +/- A*B with optional internal accumulator as the addend.
module ipsxe_floating_point_mac_pipe_v1_0
  import ipsxe_floating_point_mac_pkg::*;
#(
  parameter int unsigned A_WIDTH = 25,
  parameter int unsigned B_WIDTH = 18,
  parameter int unsigned C_WIDTH = 47,
  parameter int unsigned P_WIDTH = 48,
  parameter int unsigned LATENCY = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic [B_WIDTH-1:0] i_b,
  input  logic [C_WIDTH-1:0] i_c,
  input  logic               i_sub,
  input  logic               i_acc,
  output logic               o_valid,
  output logic [P_WIDTH-1:0] o_p,
  output logic               o_ovf
);

  localparam int unsigned M_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int unsigned S_WIDTH   = P_WIDTH + 1;
  localparam int unsigned CTL_WIDTH = C_WIDTH + 3;

  if (!mac_p_width_ok(A_WIDTH, B_WIDTH, C_WIDTH, P_WIDTH)) begin : g_bad_width
    $fatal(1, "P_WIDTH too narrow for A_WIDTH+B_WIDTH+1 or C_WIDTH+1");
  end
  if (LATENCY < MAC_LATENCY_MIN || LATENCY > MAC_LATENCY_MAX) begin : g_bad_latency
    $fatal(1, "LATENCY must be within 1..4");
  end

  logic [A_WIDTH-1:0]   a_m;
  logic [B_WIDTH-1:0]   b_m;
  logic [M_WIDTH-1:0]   prod_c;
  logic [M_WIDTH-1:0]   prod_f;
  logic [CTL_WIDTH-1:0] ctl_f;
  logic                 valid_f;
  logic                 acc_f;
  logic                 sub_f;
  logic [C_WIDTH-1:0]   c_f;
  logic [S_WIDTH-1:0]   addend;
  logic [S_WIDTH-1:0]   prod_ext;
  logic [S_WIDTH-1:0]   sum;
  logic [P_WIDTH-1:0]   p_d;
  logic                 ovf_d;
  logic                 valid_q;
  logic [P_WIDTH-1:0]   p_q;
  logic                 ovf_q;

  if (LATENCY == 1) begin : g_in_comb
    assign a_m = i_a;
    assign b_m = i_b;
  end else begin : g_in_reg
    logic [A_WIDTH-1:0] a_q;
    logic [B_WIDTH-1:0] b_q;
    always_ff @(posedge i_clk) begin
      a_q <= i_a;
      b_q <= i_b;
    end
    assign a_m = a_q;
    assign b_m = b_q;
  end

  assign prod_c = {{B_WIDTH{1'b0}}, a_m} * {{A_WIDTH{1'b0}}, b_m};

  if (LATENCY >= 3) begin : g_prod_reg
    logic [M_WIDTH-1:0] prod_q;
    always_ff @(posedge i_clk) begin
      prod_q <= prod_c;
    end
    if (LATENCY == 4) begin : g_prod_pipe
      logic [M_WIDTH-1:0] prod2_q;
      always_ff @(posedge i_clk) begin
        prod2_q <= prod_q;
      end
      assign prod_f = prod2_q;
    end else begin : g_prod_direct
      assign prod_f = prod_q;
    end
  end else begin : g_prod_comb
    assign prod_f = prod_c;
  end

  // Valid, mode bits and external addend follow the product so they meet it in the last stage.
  ipsxe_floating_point_delay_line_v1_0 #(
    .WIDTH (CTL_WIDTH),
    .DEPTH (LATENCY - 1)
  ) u_ctl_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   ({i_valid, i_acc, i_sub, i_c}),
    .o_d   (ctl_f)
  );

  assign {valid_f, acc_f, sub_f, c_f} = ctl_f;

  // The output register doubles as the accumulator, so back-to-back acc ops see the newest result.
  always_comb begin
    addend   = acc_f ? {p_q[P_WIDTH-1], p_q} : {{(S_WIDTH - C_WIDTH){1'b0}}, c_f};
    prod_ext = {{(S_WIDTH - M_WIDTH){1'b0}}, prod_f};
    sum      = sub_f ? (addend - prod_ext) : (addend + prod_ext);
    p_d      = sum[P_WIDTH-1:0];
    ovf_d    = sum[P_WIDTH] ^ sum[P_WIDTH-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_f;
      if (valid_f) begin
        p_q   <= p_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_p     = p_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_ipsxe_floating_point_mac_pipe_v1_0.sv
// Directed vector bench: default-width units at LATENCY 1..4 plus a narrow unit for overflow cases.
module tb_ipsxe_floating_point_mac_pipe_v1_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, sub, acc;
  logic [24:0] a;
  logic [17:0] b;
  logic [46:0] c;
  logic        ov [4];
  logic [47:0] op [4];
  logic        oo [4];

  logic        svalid, ssub, sacc, sov, soo;
  logic [3:0]  sa, sb;
  logic [7:0]  sc;
  logic [9:0]  sop;

  int n_assert = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ipsxe_floating_point_mac_pipe_v1_0 #(.LATENCY(g + 1)) u_dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (valid),
      .i_a     (a),
      .i_b     (b),
      .i_c     (c),
      .i_sub   (sub),
      .i_acc   (acc),
      .o_valid (ov[g]),
      .o_p     (op[g]),
      .o_ovf   (oo[g])
    );
  end

  ipsxe_floating_point_mac_pipe_v1_0 #(
    .A_WIDTH (4),
    .B_WIDTH (4),
    .C_WIDTH (8),
    .P_WIDTH (10),
    .LATENCY (4)
  ) u_small (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (svalid),
    .i_a     (sa),
    .i_b     (sb),
    .i_c     (sc),
    .i_sub   (ssub),
    .i_acc   (sacc),
    .o_valid (sov),
    .o_p     (sop),
    .o_ovf   (soo)
  );

  typedef struct {
    logic        v;
    logic [24:0] a;
    logic [17:0] b;
    logic [46:0] c;
    logic        sub;
    logic        acc;
    logic        ev;
    logic [47:0] ep;
    logic        eo;
  } vec_t;

  localparam int N  = 14;
  localparam int NS = 5;
  vec_t tv [N];
  vec_t st [NS];

  function automatic vec_t mk(input logic v, input logic [24:0] ai, input logic [17:0] bi,
                              input logic [46:0] ci, input logic s, input logic ac,
                              input logic ev, input logic [47:0] ep, input logic eo);
    vec_t r;
    r.v = v; r.a = ai; r.b = bi; r.c = ci; r.sub = s; r.acc = ac;
    r.ev = ev; r.ep = ep; r.eo = eo;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_lat(input int l, input string tag, input logic ev,
                         input logic [47:0] ep, input logic eo);
    chk($sformatf("L%0d %s o_valid", l, tag), {63'h0, ov[l-1]}, {63'h0, ev});
    chk($sformatf("L%0d %s o_p", l, tag), {16'h0, op[l-1]}, {16'h0, ep});
    chk($sformatf("L%0d %s o_ovf", l, tag), {63'h0, oo[l-1]}, {63'h0, eo});
  endtask

  task automatic chk_small(input string tag, input logic ev, input logic [9:0] ep, input logic eo);
    chk($sformatf("small %s o_valid", tag), {63'h0, sov}, {63'h0, ev});
    chk($sformatf("small %s o_p", tag), {54'h0, sop}, {54'h0, ep});
    chk($sformatf("small %s o_ovf", tag), {63'h0, soo}, {63'h0, eo});
  endtask

  task automatic drive(input vec_t t);
    valid = t.v; a = t.a; b = t.b; c = t.c; sub = t.sub; acc = t.acc;
  endtask

  task automatic drive_small(input vec_t t);
    svalid = t.v; sa = t.a[3:0]; sb = t.b[3:0]; sc = t.c[7:0]; ssub = t.sub; sacc = t.acc;
  endtask

  initial begin
    tv[0]  = mk(1'b1, 25'd3, 18'd5, 47'd100, 1'b0, 1'b0, 1'b1, 48'd115, 1'b0);
    tv[1]  = mk(1'b1, 25'd3, 18'd5, 47'd100, 1'b1, 1'b0, 1'b1, 48'd85, 1'b0);
    tv[2]  = mk(1'b1, 25'd2, 18'd2, 47'd0, 1'b0, 1'b0, 1'b1, 48'd4, 1'b0);
    tv[3]  = mk(1'b1, 25'd1, 18'd1, 47'd999, 1'b0, 1'b1, 1'b1, 48'd5, 1'b0);
    tv[4]  = mk(1'b1, 25'd1, 18'd1, 47'd999, 1'b0, 1'b1, 1'b1, 48'd6, 1'b0);
    tv[5]  = mk(1'b1, 25'd1, 18'd1, 47'd999, 1'b0, 1'b1, 1'b1, 48'd7, 1'b0);
    tv[6]  = mk(1'b1, 25'd10, 18'd10, 47'd0, 1'b0, 1'b0, 1'b1, 48'd100, 1'b0);
    tv[7]  = mk(1'b0, 25'd9, 18'd9, 47'd9, 1'b0, 1'b0, 1'b0, 48'd100, 1'b0);
    tv[8]  = mk(1'b0, 25'd9, 18'd9, 47'd9, 1'b1, 1'b1, 1'b0, 48'd100, 1'b0);
    tv[9]  = mk(1'b1, 25'd1, 18'd1, 47'd0, 1'b0, 1'b1, 1'b1, 48'd101, 1'b0);
    tv[10] = mk(1'b1, 25'd2, 18'd100, 47'd0, 1'b1, 1'b1, 1'b1, 48'hFFFF_FFFF_FF9D, 1'b0);
    tv[11] = mk(1'b1, 25'h1FF_FFFF, 18'h3_FFFF, 47'h7FFF_FFFF_FFFF, 1'b0, 1'b0,
                1'b1, 48'h87FF_FDFC_0000, 1'b1);
    tv[12] = mk(1'b1, 25'd0, 18'd0, 47'd0, 1'b0, 1'b1, 1'b1, 48'h87FF_FDFC_0000, 1'b0);
    tv[13] = mk(1'b1, 25'd1, 18'd1, 47'd0, 1'b1, 1'b1, 1'b1, 48'h87FF_FDFB_FFFF, 1'b0);

    st[0] = mk(1'b1, 25'd1, 18'd1, 47'd0, 1'b1, 1'b0, 1'b1, 48'h3FF, 1'b0);
    st[1] = mk(1'b1, 25'd15, 18'd15, 47'd255, 1'b0, 1'b0, 1'b1, 48'd480, 1'b0);
    st[2] = mk(1'b1, 25'd15, 18'd15, 47'd0, 1'b0, 1'b1, 1'b1, 48'h2C1, 1'b1);
    st[3] = mk(1'b1, 25'd15, 18'd15, 47'd0, 1'b1, 1'b1, 1'b1, 48'h1E0, 1'b1);
    st[4] = mk(1'b1, 25'd0, 18'd0, 47'd0, 1'b0, 1'b1, 1'b1, 48'h1E0, 1'b0);

    // Reset held three cycles with valid inputs present: nothing may be accepted.
    rst = 1'b1;
    drive(mk(1'b1, 25'd7, 18'd7, 47'd7, 1'b0, 1'b0, 1'b0, 48'd0, 1'b0));
    drive_small(mk(1'b1, 25'd7, 18'd7, 47'd7, 1'b0, 1'b0, 1'b0, 48'd0, 1'b0));
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      for (int l = 1; l <= 4; l++) chk_lat(l, $sformatf("reset%0d", r), 1'b0, 48'd0, 1'b0);
      chk_small($sformatf("reset%0d", r), 1'b0, 10'd0, 1'b0);
    end
    rst = 1'b0;
    svalid = 1'b0;

    for (int j = 0; j < N + 4; j++) begin
      if (j < N) drive(tv[j]);
      else valid = 1'b0;
      @(posedge clk); #1;
      for (int l = 1; l <= 4; l++) begin
        int k;
        k = j - l + 1;
        if (k < 0) chk_lat(l, "pre", 1'b0, 48'd0, 1'b0);
        else if (k < N) chk_lat(l, $sformatf("vec%0d", k), tv[k].ev, tv[k].ep, tv[k].eo);
        else chk_lat(l, "post", 1'b0, tv[N-1].ep, tv[N-1].eo);
      end
    end

    for (int j = 0; j < NS + 4; j++) begin
      int k;
      if (j < NS) drive_small(st[j]);
      else svalid = 1'b0;
      @(posedge clk); #1;
      k = j - 3;
      if (k < 0) chk_small("pre", 1'b0, 10'd0, 1'b0);
      else if (k < NS) chk_small($sformatf("vec%0d", k), st[k].ev, st[k].ep[9:0], st[k].eo);
      else chk_small("post", 1'b0, st[NS-1].ep[9:0], st[NS-1].eo);
    end

    // Two ops launched, then a one-cycle reset with a valid op presented; none may emerge.
    drive(mk(1'b1, 25'd5, 18'd5, 47'd9, 1'b0, 1'b0, 1'b0, 48'd0, 1'b0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    drive(mk(1'b1, 25'd7, 18'd7, 47'd50, 1'b0, 1'b0, 1'b0, 48'd0, 1'b0));
    @(posedge clk); #1;
    for (int l = 1; l <= 4; l++) chk_lat(l, "midrst", 1'b0, 48'd0, 1'b0);
    rst = 1'b0;
    drive(mk(1'b1, 25'd1, 18'd1, 47'd0, 1'b0, 1'b1, 1'b0, 48'd0, 1'b0));
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      valid = 1'b0;
      for (int l = 1; l <= 4; l++) begin
        if (j == l - 1) chk_lat(l, $sformatf("after_rst%0d", j), 1'b1, 48'd1, 1'b0);
        else if (j < l - 1) chk_lat(l, $sformatf("after_rst%0d", j), 1'b0, 48'd0, 1'b0);
        else chk_lat(l, $sformatf("after_rst%0d", j), 1'b0, 48'd1, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
